key_search_scheduler: RTL
=========================

Name: key_search_scheduler

Overview:
- Sequences a brute-force RC4 key search across NUM_CORES parallel decrypt/check cores on CLOCK_50.
- Splits [key_lo, key_hi] into chunks of 2^CHUNK_W keys and hands each chunk to the next idle core, round-robin.
- On the first core reporting a found key, aborts all other cores and presents the key and status on LEDR.
- Replaces the fixed, hard-wired per-core ranges and ad-hoc done cross-wiring.

Parameters:
- NUM_CORES, 4, number of cracking cores; 1..8.
- KEY_W, 24, key width in bits.
- CHUNK_W, 12, log2 of keys per dispatched chunk; CHUNK_W < KEY_W.

Ports:
- CLOCK_50  in  1  system clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; begins a search. Ignored unless state is IDLE, DONE_FOUND or DONE_EXHAUSTED.
- key_lo  in  KEY_W  first key, inclusive; sampled on start.
- key_hi  in  KEY_W  last key, inclusive; sampled on start.
- core_start  out  NUM_CORES  one-cycle pulse per core; assigns a chunk.
- core_key_lo  out  NUM_CORES*KEY_W  chunk base per core; stable from core_start until that core's core_done.
- core_key_hi  out  NUM_CORES*KEY_W  chunk last key per core, inclusive; same stability rule.
- core_abort  out  NUM_CORES  one-cycle pulse; core must stop and then pulse core_done.
- core_done  in  NUM_CORES  one-cycle pulse; chunk finished or aborted.
- core_found  in  NUM_CORES  valid with core_done; 1 = key matched.
- core_found_key  in  NUM_CORES*KEY_W  valid with core_done & core_found.
- busy  out  1  high in RUN and ABORT.
- found  out  1  high in DONE_FOUND.
- exhausted  out  1  high in DONE_EXHAUSTED.
- found_key  out  KEY_W  latched key; holds until the next accepted start.
- LEDR  out  10  [0] = found, [1] = exhausted, [2] = busy, [9:3] = 0.

Behaviour:
- Reset values:
  - state = IDLE.
  - All outputs 0: busy, found, exhausted, found_key, LEDR, core_start, core_abort, core_key_lo, core_key_hi.
  - Internal outstanding bitmap = 0; round-robin pointer = 0.
  - Reset mid-search takes effect on the next edge. Core state is the cores' own concern; each core also receives reset.
- States:
  - IDLE: waits for start.
  - RUN: dispatches chunks and collects results.
  - ABORT: waits for all outstanding cores to report.
  - DONE_FOUND, DONE_EXHAUSTED: terminal; accept a new start.
- On an accepted start:
  - Latches next_key = key_lo and key_hi; clears found_key.
  - If key_hi < key_lo, goes directly to DONE_EXHAUSTED on the next cycle.
  - Otherwise enters RUN.
- Dispatch in RUN:
  - At most one core_start per cycle.
  - Target is the first idle core (outstanding bit 0) at or after the RR pointer, wrapping. The pointer then moves to target+1 mod NUM_CORES.
  - Chunk lo = next_key; chunk hi = min(next_key + 2^CHUNK_W - 1, key_hi).
  - next_key advances to hi+1. Compute at KEY_W+1 bits so the range end at all-ones does not wrap.
  - A "range_empty" flag is set when hi == key_hi.
  - No dispatch once range_empty is set.
- Completion:
  - core_done clears that core's outstanding bit. A core freed this cycle is dispatchable from the next cycle.
  - core_done & core_found latches found_key. If several cores report found in the same cycle, the lowest index wins.
  - On found: no dispatch that cycle; pulse core_abort to every other outstanding core on the next cycle; enter ABORT.
  - Results arriving during ABORT only clear outstanding bits; found_key does not change.
- Exit conditions:
  - ABORT -> DONE_FOUND when outstanding == 0.
  - RUN -> DONE_EXHAUSTED when range_empty and outstanding == 0 and no found.
- Latency:
  - Accepted start -> first core_start: 1 cycle.
  - Last core_done -> found/exhausted: 1 cycle.
  - Found core_done -> core_abort: 1 cycle.
- A core_done on a core that is not outstanding is ignored (protocol error; bench flags it).

Decomposition:
- Package key_search_pkg: state enum typedef, key_t (logic [KEY_W-1:0]), LEDR bit index constants.
- One sub-module, rr_idle_picker:
  - Inputs: NUM_CORES idle mask and pointer.
  - Outputs: grant one-hot and grant_valid.
  - Purely combinational.
- Chunk arithmetic and the FSM stay in the top module.

Test Plan:
- NUM_CORES=4, CHUNK_W=4, key_lo=0x000000, key_hi=0x00003F, stub cores done after 20 cycles, none found -> chunks 0x00-0x0F, 0x10-0x1F, 0x20-0x2F, 0x30-0x3F issued to cores 0,1,2,3 on consecutive cycles; exhausted=1, LEDR=0x002.
- Same range, core 2 reports found key 0x000025 -> core_abort to cores 0,1,3 next cycle; found_key=0x000025 after all abort acks; LEDR=0x001.
- key_lo=0x000005, key_hi=0x000016 -> chunks 0x05-0x14 and 0x15-0x16 (truncated); only 2 core_starts; then exhausted.
- Cores 1 and 3 report found in the same cycle with keys 0x11 and 0x33 -> found_key=0x11; no further core_start after that cycle.
- key_lo=0x10, key_hi=0x0F -> exhausted 1 cycle after start; no core_start. key_hi=0xFFFFFF with the last chunk ending there -> no wrap, exhausted.
- reset asserted mid-RUN -> next cycle all outputs 0, state IDLE; start while busy ignored; start after DONE clears found_key.

Source files
------------

// File: rtl/key_search_pkg.sv
// Shared types and constants for the RC4 key-search scheduler.
package key_search_pkg;

    localparam int KEY_W_DEF = 24;

    typedef logic [KEY_W_DEF-1:0] key_t;

    typedef enum logic [2:0] {
        ST_IDLE           = 3'd0,
        ST_RUN            = 3'd1,
        ST_ABORT          = 3'd2,
        ST_DONE_FOUND     = 3'd3,
        ST_DONE_EXHAUSTED = 3'd4
    } state_e;

    localparam int LEDR_FOUND     = 0;
    localparam int LEDR_EXHAUSTED = 1;
    localparam int LEDR_BUSY      = 2;

endpackage

// File: rtl/rr_idle_picker.sv
// Combinational round-robin picker: first idle core at or after ptr, wrapping.
module rr_idle_picker
    import key_search_pkg::*;
#(
    parameter int N     = 4,
    parameter int PTR_W = 2
) (
    input  logic [N-1:0]     idle,
    input  logic [PTR_W-1:0] ptr,
    output logic [N-1:0]     grant,
    output logic             grant_valid
);

    always_comb begin
        int idx;
        idx         = 0;
        grant       = '0;
        grant_valid = 1'b0;
        for (int i = 0; i < N; i++) begin
            idx = (int'(ptr) + i) % N;
            if (!grant_valid && idle[idx]) begin
                grant[idx]  = 1'b1;
                grant_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/key_search_scheduler.sv
// Splits [key_lo, key_hi] into chunks, dispatches them round-robin to idle
// cracking cores, and aborts the rest once any core reports a found key.
module key_search_scheduler
    import key_search_pkg::*;
#(
    parameter int NUM_CORES = 4,
    parameter int KEY_W     = 24,
    parameter int CHUNK_W   = 12
) (
    input  logic                       CLOCK_50,
    input  logic                       reset,
    input  logic                       start,
    input  logic [KEY_W-1:0]           key_lo,
    input  logic [KEY_W-1:0]           key_hi,
    output logic [NUM_CORES-1:0]       core_start,
    output logic [NUM_CORES*KEY_W-1:0] core_key_lo,
    output logic [NUM_CORES*KEY_W-1:0] core_key_hi,
    output logic [NUM_CORES-1:0]       core_abort,
    input  logic [NUM_CORES-1:0]       core_done,
    input  logic [NUM_CORES-1:0]       core_found,
    input  logic [NUM_CORES*KEY_W-1:0] core_found_key,
    output logic                       busy,
    output logic                       found,
    output logic                       exhausted,
    output logic [KEY_W-1:0]           found_key,
    output logic [9:0]                 LEDR,
    output state_e                     dbg_state
);

    localparam int PTR_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
    localparam logic [KEY_W:0] CHUNK_SPAN = {{(KEY_W+1-CHUNK_W){1'b0}}, {CHUNK_W{1'b1}}};

    state_e                     state_q, state_d;
    logic [KEY_W:0]             next_key_q, next_key_d;
    logic [KEY_W-1:0]           key_hi_q, key_hi_d;
    logic                       range_empty_q, range_empty_d;
    logic [NUM_CORES-1:0]       outstanding_q, outstanding_d;
    logic [PTR_W-1:0]           rr_ptr_q, rr_ptr_d;
    logic [KEY_W-1:0]           found_key_q, found_key_d;
    logic [NUM_CORES-1:0]       core_start_q, core_start_d;
    logic [NUM_CORES-1:0]       core_abort_q, core_abort_d;
    logic [NUM_CORES*KEY_W-1:0] lo_q, lo_d, hi_q, hi_d;

    logic [NUM_CORES-1:0] grant;
    logic                 grant_valid;

    rr_idle_picker #(.N(NUM_CORES), .PTR_W(PTR_W)) u_picker (
        .idle        (~outstanding_q),
        .ptr         (rr_ptr_q),
        .grant       (grant),
        .grant_valid (grant_valid)
    );

    logic                 accept, dispatch;
    logic [NUM_CORES-1:0] done_v, found_v, out_clr;
    logic [KEY_W-1:0]     win_key, limit, chunk_hi;
    logic [KEY_W:0]       base, chunk_end;
    logic [PTR_W-1:0]     grant_idx;

    always_comb begin
        accept  = start && (state_q == ST_IDLE || state_q == ST_DONE_FOUND ||
                            state_q == ST_DONE_EXHAUSTED);
        // Reports from cores we never dispatched are ignored entirely.
        done_v  = core_done & outstanding_q;
        found_v = done_v & core_found;
        out_clr = outstanding_q & ~done_v;

        win_key = '0;
        for (int i = NUM_CORES - 1; i >= 0; i--) begin
            if (found_v[i]) win_key = core_found_key[i*KEY_W +: KEY_W];
        end
        grant_idx = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            if (grant[i]) grant_idx = PTR_W'(i);
        end

        // Chunk math carries an extra bit so a range ending at all-ones never wraps.
        base      = accept ? {1'b0, key_lo} : next_key_q;
        limit     = accept ? key_hi : key_hi_q;
        chunk_end = base + CHUNK_SPAN;
        chunk_hi  = (chunk_end > {1'b0, limit}) ? limit : chunk_end[KEY_W-1:0];

        dispatch = accept ? (key_hi >= key_lo)
                          : (state_q == ST_RUN && !range_empty_q && !(|found_v) && grant_valid);

        state_d       = state_q;
        next_key_d    = next_key_q;
        key_hi_d      = key_hi_q;
        range_empty_d = range_empty_q;
        outstanding_d = out_clr;
        rr_ptr_d      = rr_ptr_q;
        found_key_d   = found_key_q;
        core_start_d  = '0;
        core_abort_d  = '0;
        lo_d          = lo_q;
        hi_d          = hi_q;

        case (state_q)
            ST_RUN: begin
                if (|found_v) begin
                    found_key_d  = win_key;
                    core_abort_d = out_clr;
                    state_d      = (out_clr == '0) ? ST_DONE_FOUND : ST_ABORT;
                end else if (range_empty_q && out_clr == '0) begin
                    state_d = ST_DONE_EXHAUSTED;
                end
            end
            ST_ABORT: begin
                if (out_clr == '0) state_d = ST_DONE_FOUND;
            end
            default: ;
        endcase

        if (accept) begin
            key_hi_d      = key_hi;
            found_key_d   = '0;
            range_empty_d = 1'b0;
            next_key_d    = {1'b0, key_lo};
            state_d       = (key_hi < key_lo) ? ST_DONE_EXHAUSTED : ST_RUN;
        end

        if (dispatch) begin
            core_start_d                       = grant;
            outstanding_d                      = out_clr | grant;
            lo_d[grant_idx*KEY_W +: KEY_W]     = base[KEY_W-1:0];
            hi_d[grant_idx*KEY_W +: KEY_W]     = chunk_hi;
            next_key_d                         = {1'b0, chunk_hi} + 1'b1;
            range_empty_d                      = (chunk_hi == limit);
            rr_ptr_d = (grant_idx == PTR_W'(NUM_CORES - 1)) ? '0 : grant_idx + 1'b1;
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            next_key_q    <= '0;
            key_hi_q      <= '0;
            range_empty_q <= 1'b0;
            outstanding_q <= '0;
            rr_ptr_q      <= '0;
            found_key_q   <= '0;
            core_start_q  <= '0;
            core_abort_q  <= '0;
            lo_q          <= '0;
            hi_q          <= '0;
        end else begin
            state_q       <= state_d;
            next_key_q    <= next_key_d;
            key_hi_q      <= key_hi_d;
            range_empty_q <= range_empty_d;
            outstanding_q <= outstanding_d;
            rr_ptr_q      <= rr_ptr_d;
            found_key_q   <= found_key_d;
            core_start_q  <= core_start_d;
            core_abort_q  <= core_abort_d;
            lo_q          <= lo_d;
            hi_q          <= hi_d;
        end
    end

    always_comb begin
        core_start  = core_start_q;
        core_abort  = core_abort_q;
        core_key_lo = lo_q;
        core_key_hi = hi_q;
        busy        = (state_q == ST_RUN) || (state_q == ST_ABORT);
        found       = (state_q == ST_DONE_FOUND);
        exhausted   = (state_q == ST_DONE_EXHAUSTED);
        found_key   = found_key_q;
        dbg_state   = state_q;
        LEDR                 = '0;
        LEDR[LEDR_FOUND]     = found;
        LEDR[LEDR_EXHAUSTED] = exhausted;
        LEDR[LEDR_BUSY]      = busy;
    end

endmodule
